// File: rtl/scope_spi_pkg.sv
// Shared definitions for the scope SPI controllers.
// State encoding and default timing.
package scope_spi_pkg;

  typedef enum logic [2:0] {
    ST_BOOT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_SETUP = 3'd2,
    ST_SHIFT = 3'd3,
    ST_HOLD  = 3'd4,
    ST_DONE  = 3'd5
  } spi_state_t;

  localparam int DEF_CLK_DIV  = 4;
  localparam int DEF_CS_SETUP = 2;
  localparam int DEF_CS_HOLD  = 2;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/amp_gain_controller_if.sv
// Control-side bundle of the pre-amp gain writer.
// master = scope control logic, slave = writer.
interface amp_gain_controller_if;

  logic       req;
  logic [3:0] gain_a;
  logic [3:0] gain_b;
  logic       ack;
  logic       done;
  logic       spi_busy;
  logic [7:0] readback;

  modport master (
    output req, gain_a, gain_b,
    input  ack, done, spi_busy, readback
  );

  modport slave (
    input  req, gain_a, gain_b,
    output ack, done, spi_busy, readback
  );

endinterface

// File: rtl/spi_sck_gen.sv
// SCK phase/bit sequencer for one 8-bit frame.
// Counters run only while run is high.
module spi_sck_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic sck,
  output logic rise,
  output logic fall,
  output logic last
);

  localparam int PW = $clog2(2 * CLK_DIV);
  localparam logic [PW-1:0] PH_HI  = PW'(CLK_DIV);
  localparam logic [PW-1:0] PH_END = PW'(2 * CLK_DIV - 1);

  logic [PW-1:0] phase;
  logic [2:0]    bit_cnt;

  // phase wraps each bit period, bit counter steps on wrap
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase   <= '0;
      bit_cnt <= '0;
    end else if (!run) begin
      phase   <= '0;
      bit_cnt <= '0;
    end else if (phase == PH_END) begin
      phase   <= '0;
      bit_cnt <= bit_cnt + 3'd1;
    end else begin
      phase   <= phase + 1'b1;
    end
  end

  assign sck  = run && (phase >= PH_HI);
  assign rise = run && (phase == PH_HI);
  assign fall = run && (phase == PH_END);
  assign last = fall && (bit_cnt == 3'd7);

endmodule

// File: rtl/amp_gain_controller.sv
// SPI gain writer for the two-channel pre-amp.
// Boots with a default write, then serves requests.
module amp_gain_controller
  import scope_spi_pkg::*;
#(
  parameter int         CLK_DIV      = DEF_CLK_DIV,
  parameter int         CS_SETUP     = DEF_CS_SETUP,
  parameter int         CS_HOLD      = DEF_CS_HOLD,
  parameter logic [7:0] GAIN_DEFAULT = 8'h11
) (
  input  logic                  clk,
  input  logic                  rst,
  amp_gain_controller_if.slave  bus,
  output logic                  AMP_CS,
  output logic                  SPI_SCK,
  output logic                  SPI_MOSI,
  input  logic                  AMP_DOUT
);

  localparam int CW = $clog2(max2(CS_SETUP, CS_HOLD) + 1);
  localparam logic [CW-1:0] SETUP_END = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] HOLD_END  = CW'(CS_HOLD - 1);

  spi_state_t state;
  spi_state_t state_nxt;

  logic [CW-1:0] cnt;
  logic [7:0]    sreg;
  logic [7:0]    rb_shift;

  logic run;
  logic sck_int;
  logic rise;
  logic fall;
  logic last;

  logic       cs_d;
  logic       sck_d;
  logic       mosi_d;
  logic       ack_d;
  logic       done_d;
  logic       busy_d;
  logic [7:0] rb_d;

  logic       ack_q;
  logic       done_q;
  logic       busy_q;
  logic [7:0] rb_q;

  assign run = (state == ST_SHIFT);

  spi_sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck (
    .clk  (clk),
    .rst  (rst),
    .run  (run),
    .sck  (sck_int),
    .rise (rise),
    .fall (fall),
    .last (last)
  );

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_BOOT;
    else      state <= state_nxt;
  end

  // next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_BOOT:  state_nxt = ST_SETUP;
      ST_IDLE:  if (bus.req) state_nxt = ST_SETUP;
      ST_SETUP: if (cnt == SETUP_END) state_nxt = ST_SHIFT;
      ST_SHIFT: if (last) state_nxt = ST_HOLD;
      ST_HOLD:  if (cnt == HOLD_END) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_BOOT;
    endcase
  end

  // dwell counter, restarts on every state change
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    cnt <= '0;
    else if (state_nxt != state) cnt <= '0;
    else                         cnt <= cnt + 1'b1;
  end

  // gain shift-out and readback shift-in
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg     <= '0;
      rb_shift <= '0;
    end else begin
      if (state == ST_BOOT)
        sreg <= GAIN_DEFAULT;
      else if (state == ST_IDLE && bus.req)
        sreg <= {bus.gain_b, bus.gain_a};
      else if (fall)
        sreg <= {sreg[6:0], 1'b0};
      if (rise)
        rb_shift <= {rb_shift[6:0], AMP_DOUT};
    end
  end

  // next values of the registered outputs
  always_comb begin
    cs_d   = 1'b1;
    mosi_d = 1'b0;
    done_d = 1'b0;
    rb_d   = rb_q;
    unique case (1'b1)
      (state == ST_SETUP),
      (state == ST_SHIFT),
      (state == ST_HOLD): begin
        cs_d   = 1'b0;
        mosi_d = sreg[7];
      end
      (state == ST_DONE): begin
        done_d = 1'b1;
        rb_d   = rb_shift;
      end
      default: ;
    endcase
    sck_d  = sck_int;
    ack_d  = (state == ST_IDLE) && bus.req;
    busy_d = (state != ST_IDLE) || bus.req;
  end

  // output registers, pins idle on reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      AMP_CS   <= 1'b1;
      SPI_SCK  <= 1'b0;
      SPI_MOSI <= 1'b0;
      ack_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b1;
      rb_q     <= '0;
    end else begin
      AMP_CS   <= cs_d;
      SPI_SCK  <= sck_d;
      SPI_MOSI <= mosi_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      rb_q     <= rb_d;
    end
  end

  assign bus.ack      = ack_q;
  assign bus.done     = done_q;
  assign bus.spi_busy = busy_q;
  assign bus.readback = rb_q;

endmodule

// File: tb/tb_amp_gain_controller.sv
// Directed bench for the pre-amp gain writer.
// Includes a behavioural amp that echoes its previous gain.
module tb_amp_gain_controller;

  localparam int         CLK_DIV  = 4;
  localparam int         CS_SETUP = 2;
  localparam int         CS_HOLD  = 2;
  localparam logic [7:0] GDEF     = 8'h11;
  localparam int         PER      = 10;
  localparam int         CS_LOW   = CS_SETUP + 16 * CLK_DIV + CS_HOLD;
  localparam int         LAT      = CS_LOW + 1;
  localparam time        CS_LOW_T = CS_LOW * PER;
  localparam time        HALF_T   = CLK_DIV * PER;
  localparam time        GAP_T    = 2 * PER;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic AMP_CS;
  logic SPI_SCK;
  logic SPI_MOSI;
  logic AMP_DOUT = 1'b0;

  amp_gain_controller_if bus();

  amp_gain_controller #(
    .CLK_DIV      (CLK_DIV),
    .CS_SETUP     (CS_SETUP),
    .CS_HOLD      (CS_HOLD),
    .GAIN_DEFAULT (GDEF)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .AMP_CS   (AMP_CS),
    .SPI_SCK  (SPI_SCK),
    .SPI_MOSI (SPI_MOSI),
    .AMP_DOUT (AMP_DOUT)
  );

  always #5 clk = ~clk;

  logic       cs_q = 1'b1;
  logic       sck_q = 1'b0;
  logic [7:0] frame_bits = 8'h00;
  logic [7:0] last_bits = 8'h00;
  logic [7:0] amp_prev = 8'h00;
  logic [7:0] amp_sh = 8'h00;
  int         frame_rises = 0;
  int         last_rises = 0;
  time        t_cs_fall = 0;
  time        t_cs_rise = 0;
  time        t_sck_rise = 0;
  time        t_sck_fall = 0;
  time        cs_low_t = 0;
  time        cs_gap_t = 0;
  logic       sck_bad = 1'b0;
  logic       first_rise = 1'b1;
  int         ack_cnt = 0;

  // amp model and pin monitor
  always @(AMP_CS or SPI_SCK) begin
    if (AMP_CS != cs_q) begin
      if (!AMP_CS) begin
        cs_gap_t    = $time - t_cs_rise;
        t_cs_fall   = $time;
        frame_rises = 0;
        frame_bits  = 8'h00;
        sck_bad     = 1'b0;
        first_rise  = 1'b1;
        amp_sh      = amp_prev;
        AMP_DOUT    = amp_sh[7];
      end else begin
        t_cs_rise  = $time;
        cs_low_t   = $time - t_cs_fall;
        last_bits  = frame_bits;
        last_rises = frame_rises;
        if (frame_rises == 8) amp_prev = frame_bits;
      end
      cs_q = AMP_CS;
    end
    if (SPI_SCK != sck_q) begin
      if (SPI_SCK) begin
        if (AMP_CS) sck_bad = 1'b1;
        if (!first_rise && ($time - t_sck_fall) != HALF_T)
          sck_bad = 1'b1;
        first_rise  = 1'b0;
        t_sck_rise  = $time;
        frame_bits  = {frame_bits[6:0], SPI_MOSI};
        frame_rises = frame_rises + 1;
      end else begin
        if (($time - t_sck_rise) != HALF_T) sck_bad = 1'b1;
        t_sck_fall = $time;
        amp_sh     = {amp_sh[6:0], 1'b0};
        AMP_DOUT   = amp_sh[7];
      end
      sck_q = SPI_SCK;
    end
  end

  always @(posedge clk) if (bus.ack) ack_cnt = ack_cnt + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = i;
        break;
      end
    end
  endtask

  // called on the done cycle
  task automatic check_frame(input string nm,
                             input logic [7:0] mosi,
                             input logic [7:0] rb);
    chk({nm, "_readback"}, 32'(bus.readback), 32'(rb));
    chk({nm, "_busy_done"}, 32'(bus.spi_busy), 32'd1);
    chk({nm, "_cs_high"}, 32'(AMP_CS), 32'd1);
    @(negedge clk);
    chk({nm, "_done_pulse"}, 32'(bus.done), 32'd0);
    chk({nm, "_busy_fall"}, 32'(bus.spi_busy), 32'd0);
    chk({nm, "_mosi"}, 32'(last_bits), 32'(mosi));
    chk({nm, "_rises"}, 32'(last_rises), 32'd8);
    chk({nm, "_cs_low"}, 32'(cs_low_t), 32'(CS_LOW_T));
    chk({nm, "_sck_ok"}, 32'(sck_bad), 32'd0);
  endtask

  task automatic do_write(input logic [3:0] gb,
                          input logic [3:0] ga,
                          output int lat);
    @(negedge clk);
    bus.gain_b = gb;
    bus.gain_a = ga;
    bus.req    = 1'b1;
    @(negedge clk);
    chk("ack", 32'(bus.ack), 32'd1);
    chk("busy_on_ack", 32'(bus.spi_busy), 32'd1);
    bus.req = 1'b0;
    wait_done(lat);
  endtask

  // rst must be low on entry
  task automatic boot_seq(input string nm, input logic [7:0] rb);
    int lat;
    int ab;
    @(negedge clk);
    chk({nm, "_rst_cs"}, 32'(AMP_CS), 32'd1);
    chk({nm, "_rst_sck"}, 32'(SPI_SCK), 32'd0);
    chk({nm, "_rst_mosi"}, 32'(SPI_MOSI), 32'd0);
    chk({nm, "_rst_ack"}, 32'(bus.ack), 32'd0);
    chk({nm, "_rst_done"}, 32'(bus.done), 32'd0);
    chk({nm, "_rst_busy"}, 32'(bus.spi_busy), 32'd1);
    chk({nm, "_rst_rb"}, 32'(bus.readback), 32'd0);
    ab  = ack_cnt;
    rst = 1'b1;
    wait_done(lat);
    chk({nm, "_lat"}, 32'(lat), 32'(LAT + 1));
    check_frame(nm, GDEF, rb);
    chk({nm, "_no_ack"}, 32'(ack_cnt - ab), 32'd0);
  endtask

  typedef struct {
    logic [3:0] gb;
    logic [3:0] ga;
    logic [7:0] mosi;
    logic [7:0] rb;
  } vec_t;

  vec_t vt[6];

  initial begin
    int lat;
    int ab;
    logic ok;

    vt[0] = '{gb: 4'h3, ga: 4'h5, mosi: 8'h35, rb: 8'h11};
    vt[1] = '{gb: 4'hA, ga: 4'hC, mosi: 8'hAC, rb: 8'h35};
    vt[2] = '{gb: 4'hF, ga: 4'h0, mosi: 8'hF0, rb: 8'hAC};
    vt[3] = '{gb: 4'h0, ga: 4'hF, mosi: 8'h0F, rb: 8'hF0};
    vt[4] = '{gb: 4'h0, ga: 4'h0, mosi: 8'h00, rb: 8'h0F};
    vt[5] = '{gb: 4'h8, ga: 4'h1, mosi: 8'h81, rb: 8'h00};

    bus.req    = 1'b0;
    bus.gain_a = 4'h0;
    bus.gain_b = 4'h0;
    #1 rst = 1'b0;

    boot_seq("boot", 8'h00);

    for (int i = 0; i < 6; i++) begin
      do_write(vt[i].gb, vt[i].ga, lat);
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(LAT));
      check_frame($sformatf("vec%0d", i), vt[i].mosi, vt[i].rb);
    end

    // requests and gain changes while busy
    ab = ack_cnt;
    @(negedge clk);
    bus.gain_b = 4'h6;
    bus.gain_a = 4'h9;
    bus.req    = 1'b1;
    @(negedge clk);
    chk("busy_ack", 32'(bus.ack), 32'd1);
    bus.req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.req    = (i % 2 == 0);
      bus.gain_b = 4'(i);
      bus.gain_a = 4'hE;
    end
    bus.req = 1'b0;
    wait_done(lat);
    chk("busy_lat", 32'(lat), 32'(LAT - 20));
    check_frame("busy", 8'h69, 8'h81);
    chk("busy_one_ack", 32'(ack_cnt - ab), 32'd1);

    // req held high: two back-to-back writes
    ab = ack_cnt;
    @(negedge clk);
    bus.gain_b = 4'h7;
    bus.gain_a = 4'h4;
    bus.req    = 1'b1;
    wait_done(lat);
    chk("b2b_lat1", 32'(lat), 32'(LAT + 1));
    chk("b2b_rb1", 32'(bus.readback), 32'h69);
    wait_done(lat);
    bus.req = 1'b0;
    chk("b2b_lat2", 32'(lat), 32'(LAT + 1));
    chk("b2b_rb2", 32'(bus.readback), 32'h74);
    chk("b2b_mosi", 32'(last_bits), 32'h74);
    chk("b2b_gap", 32'(cs_gap_t), 32'(GAP_T));
    @(negedge clk);
    chk("b2b_busy_fall", 32'(bus.spi_busy), 32'd0);
    chk("b2b_acks", 32'(ack_cnt - ab), 32'd2);

    // reset during bit 4
    @(negedge clk);
    bus.gain_b = 4'hC;
    bus.gain_a = 4'h3;
    bus.req    = 1'b1;
    @(negedge clk);
    bus.req = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (frame_rises == 5) begin
        ok = 1'b1;
        break;
      end
    end
    chk("mid_reach_bit4", 32'(ok), 32'd1);
    chk("mid_sck_high", 32'(SPI_SCK), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("mid_async_cs", 32'(AMP_CS), 32'd1);
    chk("mid_async_sck", 32'(SPI_SCK), 32'd0);
    chk("mid_async_busy", 32'(bus.spi_busy), 32'd1);
    boot_seq("reboot", 8'h74);

    do_write(4'h2, 4'hB, lat);
    chk("post_lat", 32'(lat), 32'(LAT));
    check_frame("post", 8'h2B, 8'h11);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
